pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 176 +++++++++++++++++
 tb/tb_pll_reset_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for a stable lock, then releases
// per-domain resets in order. Optional lock-loss counter enabled by PLL_RESET_SEQ_LOSS_CNT_EN.
module pll_reset_seq #(
    parameter int NUM_DOMAINS         = 5,
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int RELEASE_GAP         = 4
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   relock_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic                   err_timeout,
    output logic [7:0]             lock_loss_cnt
);

    localparam int HW = $clog2(RST_HOLD_CYCLES) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int GW = $clog2(RELEASE_GAP) + 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] ST_LAST   = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(RELEASE_GAP - 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_lock_meta;
    logic                   r_lock_s;
    logic [HW-1:0]          r_hold_cnt;
    logic [TW-1:0]          r_to_cnt;
    logic [SW-1:0]          r_st_cnt;
    logic [GW-1:0]          r_gap_cnt;
    logic                   r_pll_rst;
    logic [NUM_DOMAINS-1:0] r_domain_rst;
    logic                   r_ready;
    logic                   r_err_timeout;

    logic                   w_lock_lost;
    logic [NUM_DOMAINS-1:0] w_domain_rst_step;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    assign w_lock_lost = !r_lock_s && ((r_state == S_RELEASE) || (r_state == S_RUN));

    // Clearing the lowest set bit releases domains in index order: 11111 -> 11110 -> 11100 ...
    assign w_domain_rst_step = r_domain_rst & (r_domain_rst - NUM_DOMAINS'(1));

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state       <= S_RESET_PLL;
            r_hold_cnt    <= '0;
            r_to_cnt      <= '0;
            r_st_cnt      <= '0;
            r_gap_cnt     <= '0;
            r_pll_rst     <= 1'b1;
            r_domain_rst  <= '1;
            r_ready       <= 1'b0;
            r_err_timeout <= 1'b0;
        end else if (relock_req || w_lock_lost) begin
            if (relock_req)
                r_err_timeout <= 1'b0;
            r_state      <= S_RESET_PLL;
            r_hold_cnt   <= '0;
            r_to_cnt     <= '0;
            r_st_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_pll_rst    <= 1'b1;
            r_domain_rst <= '1;
            r_ready      <= 1'b0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state    <= S_WAIT_LOCK;
                        r_hold_cnt <= '0;
                        r_to_cnt   <= '0;
                        r_pll_rst  <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        r_state  <= S_STABLE;
                        r_st_cnt <= '0;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state       <= S_RESET_PLL;
                        r_to_cnt      <= '0;
                        r_hold_cnt    <= '0;
                        r_pll_rst     <= 1'b1;
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                S_STABLE: begin
                    if (!r_lock_s) begin
                        r_state  <= S_WAIT_LOCK;
                        r_to_cnt <= '0;
                        r_st_cnt <= '0;
                    end else if (r_st_cnt == ST_LAST) begin
                        r_state      <= S_RELEASE;
                        r_st_cnt     <= '0;
                        r_gap_cnt    <= '0;
                        r_domain_rst <= w_domain_rst_step;
                    end else begin
                        r_st_cnt <= r_st_cnt + SW'(1);
                    end
                end
                S_RELEASE: begin
                    if (r_domain_rst == '0) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt    <= '0;
                        r_domain_rst <= w_domain_rst_step;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                S_RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state      <= S_RESET_PLL;
                    r_hold_cnt   <= '0;
                    r_pll_rst    <= 1'b1;
                    r_domain_rst <= '1;
                    r_ready      <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst     = r_pll_rst;
    assign domain_rst  = r_domain_rst;
    assign ready       = r_ready;
    assign err_timeout = r_err_timeout;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst)
            r_loss_cnt <= 8'd0;
        else if (w_lock_lost && (r_loss_cnt != 8'hFF))
            r_loss_cnt <= r_loss_cnt + 8'd1;
    end

    assign lock_loss_cnt = r_loss_cnt;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq: expected output snapshots are queued when stimulus is
// applied and compared once the stated number of refclk edges has elapsed.
module tb_pll_reset_seq;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic [4:0] domain_rst;
    logic       ready;
    logic       err_timeout;
    logic [7:0] lock_loss_cnt;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] loss_exp = 8'd0;

    pll_reset_seq #(
        .NUM_DOMAINS        (5),
        .RST_HOLD_CYCLES    (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(64),
        .RELEASE_GAP        (2)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .domain_rst   (domain_rst),
        .ready        (ready),
        .err_timeout  (err_timeout),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial forever #5 refclk = ~refclk;

    function automatic logic [15:0] mk(input logic p, input logic [4:0] d, input logic r,
                                       input logic e, input logic [7:0] c);
        return {p, d, r, e, c};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic count_loss();
        if (LOSS_EN && loss_exp != 8'd255)
            loss_exp = loss_exp + 8'd1;
    endtask

    task automatic check_head();
        exp_t        x;
        logic [15:0] obs;
        x   = sb_q.pop_front();
        obs = {pll_rst, domain_rst, ready, err_timeout, lock_loss_cnt};
        n_vec++;
        assert (obs === x.exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
        end
        $display("%0t %s obs=%h exp=%h", $time, x.tag, obs, x.exp);
    endtask

    task automatic expect_after(input int n, input string tag, input logic [15:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb_q.push_back(x);
        cyc(n);
        check_head();
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b1;
        relock_req = 1'b0;
        cyc(2);
        expect_after(0, "reset_state", mk(1, 5'h1F, 0, 0, 8'd0));
        rst = 1'b0;

        // Power-up sequence with lock present from the start
        expect_after(3, "hold_high",   mk(1, 5'h1F, 0, 0, loss_exp));
        expect_after(1, "hold_done",   mk(0, 5'h1F, 0, 0, loss_exp));
        expect_after(8, "stable_end",  mk(0, 5'h1F, 0, 0, loss_exp));
        expect_after(1, "rel_d0",      mk(0, 5'h1E, 0, 0, loss_exp));
        expect_after(1, "rel_d0_hold", mk(0, 5'h1E, 0, 0, loss_exp));
        expect_after(1, "rel_d1",      mk(0, 5'h1C, 0, 0, loss_exp));
        expect_after(2, "rel_d2",      mk(0, 5'h18, 0, 0, loss_exp));
        expect_after(2, "rel_d3",      mk(0, 5'h10, 0, 0, loss_exp));
        expect_after(2, "rel_d4",      mk(0, 5'h00, 0, 0, loss_exp));
        expect_after(1, "run",         mk(0, 5'h00, 1, 0, loss_exp));

        // Lock loss in RUN: two sync cycles then reaction
        pll_locked = 1'b0;
        expect_after(2, "loss_sync",   mk(0, 5'h00, 1, 0, loss_exp));
        count_loss();
        expect_after(1, "loss_react",  mk(1, 5'h1F, 0, 0, loss_exp));

        // Lock stays absent: timeout and retries
        expect_after(4,  "wl_enter",     mk(0, 5'h1F, 0, 0, loss_exp));
        expect_after(63, "wl_before_to", mk(0, 5'h1F, 0, 0, loss_exp));
        expect_after(1,  "timeout",      mk(1, 5'h1F, 0, 1, loss_exp));
        expect_after(4,  "retry_wl",     mk(0, 5'h1F, 0, 1, loss_exp));
        expect_after(64, "timeout2",     mk(1, 5'h1F, 0, 1, loss_exp));
        expect_after(2,  "retry_hold",   mk(1, 5'h1F, 0, 1, loss_exp));

        // relock_req mid-hold clears the error and restarts the hold count
        relock_req = 1'b1;
        expect_after(1, "relock_clr",  mk(1, 5'h1F, 0, 0, loss_exp));
        relock_req = 1'b0;
        expect_after(3, "relock_hold", mk(1, 5'h1F, 0, 0, loss_exp));
        expect_after(1, "relock_wl",   mk(0, 5'h1F, 0, 0, loss_exp));

        // One-cycle lock glitch at STABLE count 5 forces a fresh stable window
        pll_locked = 1'b1;
        cyc(6);
        pll_locked = 1'b0;
        cyc(1);
        pll_locked = 1'b1;
        expect_after(10, "glitch_hold", mk(0, 5'h1F, 0, 0, loss_exp));
        expect_after(1,  "glitch_rel",  mk(0, 5'h1E, 0, 0, loss_exp));
        expect_after(9,  "run2",        mk(0, 5'h00, 1, 0, loss_exp));

        // Repeated lock losses drive the counter into saturation
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            count_loss();
            expect_after(3, $sformatf("loss%0d", i), mk(1, 5'h1F, 0, 0, loss_exp));
            pll_locked = 1'b1;
            cyc(13);
        end
        expect_after(0, "sat_rel", mk(0, 5'h1E, 0, 0, loss_exp));
        expect_after(9, "sat_run", mk(0, 5'h00, 1, 0, loss_exp));

        // relock_req from RUN: full sequence, loss count untouched
        relock_req = 1'b1;
        expect_after(1, "relock_run", mk(1, 5'h1F, 0, 0, loss_exp));
        relock_req = 1'b0;
        expect_after(13, "relock_rel",  mk(0, 5'h1E, 0, 0, loss_exp));
        expect_after(9,  "relock_full", mk(0, 5'h00, 1, 0, loss_exp));

        // Asynchronous reset in the middle of RELEASE
        relock_req = 1'b1;
        expect_after(1, "relock_again", mk(1, 5'h1F, 0, 0, loss_exp));
        relock_req = 1'b0;
        expect_after(15, "pre_rst", mk(0, 5'h1C, 0, 0, loss_exp));
        #2;
        rst      = 1'b1;
        loss_exp = 8'd0;
        #1;
        expect_after(0, "async_rst", mk(1, 5'h1F, 0, 0, 8'd0));
        cyc(2);
        rst = 1'b0;
        expect_after(3, "post_hold", mk(1, 5'h1F, 0, 0, 8'd0));
        expect_after(1, "post_wl",   mk(0, 5'h1F, 0, 0, 8'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
